// File: rtl/mem_responder.sv
// mem_responder: word-addressed storage behind the multi-cycle core's memory port.
// Each access takes WAIT_STATES extra cycles and ends with a one-cycle ready pulse.
// Define MEM_RESPONDER_BE_EN to add the byte-enable write port.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESPONDER_BE_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]    state;
  logic [3:0]    count;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
`ifdef MEM_RESPONDER_BE_EN
  logic [3:0]    be_q;
`endif
  logic [31:0]   mem [DEPTH_WORDS];

  logic          acc_we;
  logic          acc_bad;
  logic          enter_resp;
  logic [31:0]   acc_addr;
  logic [AW-1:0] acc_idx;

  // In IDLE the access decodes straight off the bus so a zero-wait request can respond next cycle.
  always_comb begin
    acc_we   = we_q;
    acc_addr = addr_q;
    if (state == IDLE) begin
      acc_we   = we;
      acc_addr = addr;
    end
    acc_idx    = acc_addr[AW+1:2];
    acc_bad    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
    enter_resp = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                 ((state == WAIT) && (count == 4'd1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
`ifdef MEM_RESPONDER_BE_EN
      be_q    <= 4'd0;
`endif
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      ready <= enter_resp;
      err   <= enter_resp && acc_bad;
      if (enter_resp) begin
        if (acc_bad) begin
          rdata <= 32'd0;
        end else if (!acc_we) begin
          rdata <= mem[acc_idx];
        end
      end
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
`ifdef MEM_RESPONDER_BE_EN
            be_q    <= be;
`endif
            count   <= WAIT_LOAD;
            state   <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The array commits at the edge closing RESP; a reset inside RESP forces IDLE first, so nothing is written.
  always_ff @(posedge clk) begin
    if ((state == RESP) && we_q && !acc_bad) begin
`ifdef MEM_RESPONDER_BE_EN
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[acc_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
`else
      mem[acc_idx] <= wdata_q;
`endif
    end
  end

endmodule
